updown_count_arbiter: RTL and testbench
=======================================

UPDOWN_COUNT_ARBITER -- requirements
Module: updown_count_arbiter

Interface
REQ-001 Parameter list SHALL be, one per line: name, default, meaning.
  WIDTH  5   counter width in bits
  MAX    15  upper count limit, 0 < MAX < 2^WIDTH
REQ-002 Port list SHALL be, one per line: name  direction  width  meaning.
  clk         input   1      single clock, rising edge
  reset       input   1      asynchronous, active-low reset
  enable      input   1      step qualifier; low pauses a run
  clr         input   1      synchronous abort and counter clear
  req0_valid  input   1      requester 0 command valid
  req0_dir    input   1      requester 0 direction, 0=up, 1=down
  req0_len    input   4      requester 0 step count
  req0_ready  output  1      requester 0 command accepted
  req1_valid  input   1      requester 1 command valid
  req1_dir    input   1      requester 1 direction, 0=up, 1=down
  req1_len    input   4      requester 1 step count
  req1_ready  output  1      requester 1 command accepted
  count       output  WIDTH  shared counter value
  grant       output  2      one-hot owner of the current run
  busy        output  1      high in RUN or DONE
  done        output  1      one-cycle pulse at run completion
  sat         output  1      current or last run stopped at a limit

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and DONE, all registered.
REQ-004 In IDLE, reqN_ready SHALL be high only for the requester selected this cycle; ready SHALL be low in every other state.
REQ-005 Selection SHALL work as follows:
  - If one valid is high, that requester is selected.
  - If both are high, the round-robin pointer rr decides: rr=0 selects requester 0.
REQ-006 A command SHALL be accepted when reqN_valid and reqN_ready are both high. On acceptance, the block SHALL latch dir and len into internal registers dir_q and rem.
REQ-007 On acceptance, the block SHALL:
  - set grant to the winner,
  - set rr to point at the other requester,
  - clear sat,
  - enter RUN if len != 0, or DONE if len == 0.
REQ-008 In RUN, on each cycle with enable=1:
  - count SHALL change by exactly 1 (+1 if dir_q=0, -1 if dir_q=1),
  - rem SHALL decrement by 1.
REQ-009 In RUN with enable=0, count, rem and the state SHALL hold.
REQ-010 Clamp: in RUN with enable=1, if dir_q=0 and count==MAX, or dir_q=1 and count==0:
  - count SHALL NOT change,
  - sat SHALL be set,
  - the FSM SHALL go to DONE.
  The counter never wraps.
REQ-011 In RUN with enable=1 and rem==1, the block SHALL perform the final step and go to DONE. The total number of steps per run SHALL equal len unless clamped.
REQ-012 DONE SHALL last exactly one cycle with done=1, then return to IDLE and clear grant to 0. A new command SHALL NOT be accepted in the DONE cycle.
REQ-013 count SHALL hold its value between runs; successive runs continue from the current value.
REQ-014 Abort: clr=1 in any state SHALL, on the next edge:
  - set count=0, grant=0 and sat=0,
  - enter IDLE,
  - not pulse done.
  clr SHALL take priority over acceptance, and ready SHALL be low while clr=1.
REQ-015 busy SHALL be high exactly when the state is RUN or DONE.
REQ-016 Input commands that are not accepted SHALL have no effect; a requester holds valid until it sees ready.

Reset
REQ-017 reset=0 SHALL asynchronously force the following, independent of clk:
  - state=IDLE,
  - count=0, grant=0, busy=0, done=0, sat=0,
  - rem=0, dir_q=0, rr=0.
REQ-018 Reset deassertion SHALL take effect at the next rising clk edge.
REQ-019 Reset asserted mid-run SHALL abandon the run with no done pulse.

Verification
REQ-020 Run up: count=0, req0 up len=5, enable=1 -> ready0 pulses once, count 1..5 on consecutive cycles, done one cycle later, sat=0.
REQ-021 Clamp: count=13, req1 up len=6 -> count 14, 15, then sat=1, done pulse; count stays 15.
REQ-022 Contention: both valid from IDLE with rr=0 -> req0 served first, then req1 (after one DONE and one IDLE cycle); repeat both -> req0 then req1 again.
REQ-023 Pause: down run len=4 from count=10 with enable low for 3 cycles mid-run -> count 10, 9, 8 (hold 3 cycles), 7, 6, then done; exactly 4 steps.
REQ-024 Abort and reset: clr during RUN at count=7 -> count=0, grant=0, no done. reset=0 asserted between clk edges -> all outputs 0 immediately.
REQ-025 Zero length: req0 len=0 -> accepted, count unchanged, done pulses the cycle after acceptance.

Source files
------------

// File: rtl/updown_count_arbiter.sv
// Shared saturating up/down counter driven by two requesters.
// Round-robin arbitration picks one command per run.
module updown_count_arbiter #(
  parameter int WIDTH = 5,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clr,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [3:0]       req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [3:0]       req1_len,
  output logic             req1_ready,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       grant_q, grant_d;
  logic             sat_q, sat_d;
  logic             dir_q, dir_d;
  logic [3:0]       rem_q, rem_d;
  logic             rr_q, rr_d;

  logic       sel0, sel1;
  logic       idle_ok;
  logic       at_lim;
  logic [3:0] len;

  always_comb begin
    sel0    = req0_valid & (~req1_valid | ~rr_q);
    sel1    = req1_valid & (~req0_valid | rr_q);
    // ready is masked during reset so every output reads 0 at once
    idle_ok = (state_q == IDLE) & ~clr & reset;
    req0_ready = idle_ok & sel0;
    req1_ready = idle_ok & sel1;
    len     = sel1 ? req1_len : req0_len;
    at_lim  = dir_q ? (count_q == '0) : (count_q == MAX_V);

    state_d = state_q;
    count_d = count_q;
    grant_d = grant_q;
    sat_d   = sat_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    rr_d    = rr_q;

    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      grant_d = '0;
      sat_d   = 1'b0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel0 | sel1) begin
            grant_d = {sel1, sel0};
            rr_d    = sel0;
            sat_d   = 1'b0;
            dir_d   = sel1 ? req1_dir : req0_dir;
            rem_d   = len;
            state_d = (len != 4'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (enable) begin
            if (at_lim) begin
              sat_d   = 1'b1;
              state_d = DONE;
            end else begin
              count_d = dir_q ? count_q - ONE_V
                              : count_q + ONE_V;
              rem_d   = rem_q - 4'd1;
              if (rem_q == 4'd1) state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          grant_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_q <= '0;
      sat_q   <= 1'b0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
      sat_q   <= sat_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      rr_q    <= rr_d;
    end
  end

  assign count = count_q;
  assign grant = grant_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign sat   = sat_q;

endmodule

// File: tb/tb_updown_count_arbiter.sv
// Directed bench for updown_count_arbiter.
// Table of per-cycle vectors plus hand sequences.
module tb_updown_count_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, clr;
  logic       req0_valid, req0_dir, req0_ready;
  logic [3:0] req0_len;
  logic       req1_valid, req1_dir, req1_ready;
  logic [3:0] req1_len;
  logic [4:0] count;
  logic [1:0] grant;
  logic       busy, done, sat;

  int pass_cnt = 0;
  int total    = 0;

  updown_count_arbiter #(.WIDTH(5), .MAX(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr),
    .req0_valid(req0_valid), .req0_dir(req0_dir),
    .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir),
    .req1_len(req1_len), .req1_ready(req1_ready),
    .count(count), .grant(grant), .busy(busy),
    .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       v0, d0;
    logic [3:0] l0;
    logic       v1, d1;
    logic [3:0] l1;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic c, input logic v0, input logic d0,
    input int l0, input logic v1, input logic d1,
    input int l1, input int cnt, input int g,
    input logic b, input logic dn, input logic s,
    input logic r0, input logic r1);
    vec_t v;
    v.clr = c;
    v.v0 = v0; v.d0 = d0; v.l0 = 4'(l0);
    v.v1 = v1; v.d1 = d1; v.l1 = 4'(l1);
    v.exp = {5'(cnt), 2'(g), b, dn, s, r0, r1};
    tbl.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] outs();
    return {count, grant, busy, done, sat,
            req0_ready, req1_ready};
  endfunction

  task automatic issue(input int r, input logic d,
                       input int l);
    int n;
    logic rdy;
    if (r == 0) begin
      req0_valid = 1; req0_dir = d; req0_len = 4'(l);
    end else begin
      req1_valid = 1; req1_dir = d; req1_len = 4'(l);
    end
    #1;
    n = 0;
    rdy = (r == 0) ? req0_ready : req1_ready;
    while (!rdy && n < 20) begin
      cycle();
      rdy = (r == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!rdy) begin
      total++;
      $display("FAIL issue_timeout: ready 0 expected 1");
    end
    cycle();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      cycle();
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic do_clr();
    clr = 1;
    cycle();
    clr = 0;
  endtask

  initial begin
    reset = 0; enable = 1; clr = 0;
    req0_valid = 0; req0_dir = 0; req0_len = 0;
    req1_valid = 0; req1_dir = 0; req1_len = 0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_state", 32'(outs()), 32'd0);
    @(negedge clk);
    reset = 1;
    cycle();

    // contention: req0 first (rr=0), then req1, twice
    add(0, 1,0,1, 1,0,1,  0,0,0,0,0, 1,0);
    add(0, 0,0,0, 1,0,1,  0,1,1,0,0, 0,0);
    add(0, 0,0,0, 1,0,1,  1,1,1,1,0, 0,0);
    add(0, 0,0,0, 1,0,1,  1,0,0,0,0, 0,1);
    add(0, 0,0,0, 0,0,0,  1,2,1,0,0, 0,0);
    add(0, 0,0,0, 0,0,0,  2,2,1,1,0, 0,0);
    add(0, 1,0,1, 1,0,1,  2,0,0,0,0, 1,0);
    add(0, 0,0,0, 1,0,1,  2,1,1,0,0, 0,0);
    add(0, 0,0,0, 1,0,1,  3,1,1,1,0, 0,0);
    add(0, 0,0,0, 1,0,1,  3,0,0,0,0, 0,1);
    add(0, 0,0,0, 0,0,0,  3,2,1,0,0, 0,0);
    add(0, 0,0,0, 0,0,0,  4,2,1,1,0, 0,0);
    // clr beats acceptance, then run up len 5
    add(1, 1,0,5, 0,0,0,  4,0,0,0,0, 0,0);
    add(0, 1,0,5, 0,0,0,  0,0,0,0,0, 1,0);
    add(0, 0,0,0, 0,0,0,  0,1,1,0,0, 0,0);
    add(0, 0,0,0, 0,0,0,  1,1,1,0,0, 0,0);
    add(0, 0,0,0, 0,0,0,  2,1,1,0,0, 0,0);
    add(0, 0,0,0, 0,0,0,  3,1,1,0,0, 0,0);
    add(0, 0,0,0, 0,0,0,  4,1,1,0,0, 0,0);
    add(0, 0,0,0, 0,0,0,  5,1,1,1,0, 0,0);
    // zero length
    add(0, 1,0,0, 0,0,0,  5,0,0,0,0, 1,0);
    add(0, 0,0,0, 0,0,0,  5,1,1,1,0, 0,0);
    add(0, 0,0,0, 0,0,0,  5,0,0,0,0, 0,0);

    foreach (tbl[i]) begin
      clr = tbl[i].clr;
      req0_valid = tbl[i].v0; req0_dir = tbl[i].d0;
      req0_len = tbl[i].l0;
      req1_valid = tbl[i].v1; req1_dir = tbl[i].d1;
      req1_len = tbl[i].l1;
      #2;
      check($sformatf("vec%0d", i), 32'(outs()),
            32'(tbl[i].exp));
      @(posedge clk);
      #1;
    end
    clr = 0; req0_valid = 0; req1_valid = 0;

    // clamp at MAX
    do_clr();
    issue(0, 0, 13);
    wait_idle();
    check("clamp_pre", 32'(count), 32'd13);
    issue(1, 0, 6);
    check("clamp_run", 32'({count, grant, busy}),
          32'({5'd13, 2'd2, 1'b1}));
    cycle();
    check("clamp_14", 32'(count), 32'd14);
    cycle();
    check("clamp_15", 32'({count, sat}), 32'({5'd15, 1'b0}));
    cycle();
    check("clamp_hit", 32'({count, sat, done}),
          32'({5'd15, 1'b1, 1'b1}));
    cycle();
    check("clamp_after", 32'({count, grant, sat, done, busy}),
          32'({5'd15, 2'd0, 1'b1, 1'b0, 1'b0}));

    // pause during a down run
    do_clr();
    issue(0, 0, 10);
    wait_idle();
    check("pause_pre", 32'(count), 32'd10);
    issue(1, 1, 4);
    check("pause_10", 32'({count, sat}), 32'({5'd10, 1'b0}));
    cycle();
    check("pause_9", 32'(count), 32'd9);
    cycle();
    check("pause_8", 32'(count), 32'd8);
    enable = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("pause_hold%0d", k),
            32'({count, busy, done}), 32'({5'd8, 1'b1, 1'b0}));
    end
    enable = 1;
    cycle();
    check("pause_7", 32'({count, done}), 32'({5'd7, 1'b0}));
    cycle();
    check("pause_6", 32'({count, done, sat}),
          32'({5'd6, 1'b1, 1'b0}));
    cycle();
    check("pause_end", 32'({count, busy}), 32'({5'd6, 1'b0}));

    // abort mid-run
    do_clr();
    issue(0, 0, 10);
    repeat (7) cycle();
    check("abort_pre", 32'({count, busy}), 32'({5'd7, 1'b1}));
    clr = 1;
    req1_valid = 1; req1_len = 4'd1;
    #1;
    check("abort_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    cycle();
    clr = 0; req1_valid = 0;
    check("abort_out", 32'({count, grant, busy, done, sat}), 32'd0);
    cycle();
    check("abort_nodone", 32'({done, busy}), 32'd0);

    // asynchronous reset mid-run
    issue(0, 0, 5);
    cycle();
    cycle();
    check("rst_pre", 32'(count), 32'd2);
    #3;
    reset = 0;
    req0_valid = 1; req0_len = 4'd2;
    #1;
    check("rst_async", 32'(outs()), 32'd0);
    req0_valid = 0;
    #2;
    reset = 1;
    cycle();
    check("rst_after", 32'({count, busy, done}), 32'd0);

    // rr restarts at 0 after reset
    req0_valid = 1; req0_len = 4'd2;
    req1_valid = 1; req1_len = 4'd1;
    #1;
    check("rst_rr", 32'({req0_ready, req1_ready}), 32'd2);
    req1_valid = 0;
    cycle();
    req0_valid = 0;
    wait_idle();
    check("rst_run", 32'(count), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded limit");
    $fatal(1);
  end

endmodule
